// File: rtl/exe_mem_skid_reg.sv
// rtl/exe_mem_skid_reg.sv - EXE->MEM pipeline register with 2-entry skid buffer and flush
// Optional saturating stall/flush counters with EXE_MEM_PERF_CNT_EN.
module exe_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              exe_valid,
  output logic              exe_ready,
  input  logic [DATA_W-1:0] exe_sw_o,
  input  logic [DATA_W-1:0] exe_write_o,
  input  logic [DATA_W-1:0] exe_alu_result,
  input  logic [ADDR_W-1:0] exe_write_addr_o,
  input  logic              exe_lwsrc,
  input  logic              exe_movsrc,
  input  logic              exe_reg_write,
  input  logic              exe_DM_read,
  input  logic              exe_DM_write,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_sw_o,
  output logic [DATA_W-1:0] mem_write_o,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [ADDR_W-1:0] mem_write_addr_o,
  output logic              mem_lwsrc,
  output logic              mem_movsrc,
  output logic              mem_reg_write,
  output logic              mem_DM_read,
  output logic              mem_DM_write
`ifdef EXE_MEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int PL_W = 3 * DATA_W + ADDR_W + 5;

  logic [PL_W-1:0] in_pl;
  logic [PL_W-1:0] out_q;
  logic [PL_W-1:0] skid_q;
  logic            out_valid;
  logic            skid_valid;
  logic            accept;
  logic            consume;

  assign in_pl = {exe_sw_o, exe_write_o, exe_alu_result, exe_write_addr_o,
                  exe_lwsrc, exe_movsrc, exe_reg_write, exe_DM_read, exe_DM_write};

  // Ready depends only on registered state, so no combinational path from mem_ready.
  assign exe_ready = !skid_valid;
  assign accept    = exe_valid && exe_ready;
  assign consume   = out_valid && mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || consume) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q     <= in_pl;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_pl;
      skid_valid <= 1'b1;
    end
  end

  logic ctl_reg_write;
  logic ctl_dm_read;
  logic ctl_dm_write;

  assign {mem_sw_o, mem_write_o, mem_alu_result, mem_write_addr_o,
          mem_lwsrc, mem_movsrc, ctl_reg_write, ctl_dm_read, ctl_dm_write} = out_q;

  // Side-effecting controls must never fire from a stale, invalid entry.
  assign mem_valid     = out_valid;
  assign mem_reg_write = ctl_reg_write && out_valid;
  assign mem_DM_read   = ctl_dm_read   && out_valid;
  assign mem_DM_write  = ctl_dm_write  && out_valid;

`ifdef EXE_MEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !mem_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule
